// File: rtl/jxli_fp8_mul.sv
// rtl/jxli_fp8_mul.sv - serial-load FP8 (1/4/3, bias 7) multiplier with nibble-wide operand bus
module jxli_fp8_mul (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    typedef enum logic [2:0] {
        LOAD_A_HI,
        LOAD_A_LO,
        LOAD_B_HI,
        LOAD_B_LO,
        COMPUTE,
        DONE
    } state_t;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [3:0] data;
    logic       unused_io7;

    assign clock      = io_in[0];
    assign reset      = io_in[1];
    assign enable     = io_in[2];
    assign data       = io_in[6:3];
    assign unused_io7 = io_in[7];

    state_t     state;
    state_t     state_next;
    logic [7:0] a;
    logic [7:0] b;
    logic       rs;
    logic [3:0] ce;
    logic [2:0] cm;

    logic              a_nan, a_inf, a_zero;
    logic              b_nan, b_inf, b_zero;
    logic [7:0]        p;
    logic signed [6:0] e_sum;
    logic              r_s;
    logic [3:0]        r_e;
    logic [2:0]        r_m;

    assign a_nan  = (a[6:3] == 4'hf) && (a[2:0] != 3'd0);
    assign a_inf  = (a[6:3] == 4'hf) && (a[2:0] == 3'd0);
    assign a_zero = (a[6:3] == 4'h0);
    assign b_nan  = (b[6:3] == 4'hf) && (b[2:0] != 3'd0);
    assign b_inf  = (b[6:3] == 4'hf) && (b[2:0] == 3'd0);
    assign b_zero = (b[6:3] == 4'h0);

    assign p     = {4'b0001, a[2:0]} * {4'b0001, b[2:0]};
    // Normalisation bump (p[7]) is folded into the biased exponent sum.
    assign e_sum = $signed({3'b000, a[6:3]}) + $signed({3'b000, b[6:3]})
                 - 7'sd7 + $signed({6'b000000, p[7]});
    assign r_s   = a[7] ^ b[7];

    always_comb begin
        r_e = 4'h0;
        r_m = 3'd0;
        if (a_nan || b_nan || ((a_inf || b_inf) && (a_zero || b_zero))) begin
            r_e = 4'hf;
            r_m = 3'd7;
        end else if (a_inf || b_inf) begin
            r_e = 4'hf;
        end else if (a_zero || b_zero) begin
            r_e = 4'h0;
        end else if (e_sum >= 7'sd15) begin
            r_e = 4'hf;
        end else if (e_sum > 7'sd0) begin
            r_e = e_sum[3:0];
            r_m = p[7] ? p[6:4] : p[5:3];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD_A_HI: if (enable) state_next = LOAD_A_LO;
            LOAD_A_LO: if (enable) state_next = LOAD_B_HI;
            LOAD_B_HI: if (enable) state_next = LOAD_B_LO;
            LOAD_B_LO: if (enable) state_next = COMPUTE;
            COMPUTE:   state_next = DONE;
            DONE:      state_next = DONE;
            default:   state_next = LOAD_A_HI;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LOAD_A_HI;
            a     <= 8'h00;
            b     <= 8'h00;
            rs    <= 1'b0;
            ce    <= 4'h0;
            cm    <= 3'd0;
        end else begin
            state <= state_next;
            case (state)
                LOAD_A_HI: if (enable) a[7:4] <= data;
                LOAD_A_LO: if (enable) a[3:0] <= data;
                LOAD_B_HI: if (enable) b[7:4] <= data;
                LOAD_B_LO: if (enable) b[3:0] <= data;
                COMPUTE: begin
                    rs <= r_s;
                    ce <= r_e;
                    cm <= r_m;
                end
                default: ;
            endcase
        end
    end

    assign io_out = (state == DONE) ? {rs, ce, cm} : 8'h00;
endmodule

// File: tb/tb_jxli_fp8_mul.sv
// tb/tb_jxli_fp8_mul.sv - scoreboard bench for jxli_fp8_mul with directed vectors
module tb_jxli_fp8_mul;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] data = 4'h0;
    logic       b7 = 1'b0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {b7, data, en, rst, clk};

    jxli_fp8_mul dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        int         due;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cycle = cycle + 1;

    // Monitor: compare every expectation whose due cycle has arrived.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cycle) begin
            checks = checks + 1;
            if (sb[0].due < cycle) begin
                errors = errors + 1;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)",
                         sb[0].name, sb[0].due, cycle);
            end else if (io_out !== sb[0].val) begin
                errors = errors + 1;
                $display("FAIL %s: io_out=%02h expected %02h at cycle %0d",
                         sb[0].name, io_out, sb[0].val, cycle);
            end
            void'(sb.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input logic [7:0] v, input int due, input string name);
        exp_t e;
        e.val = v;
        e.due = due;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b1;
        data = 4'($urandom);
        cyc();
        expect_at(8'h00, cycle, "reset_out");
        rst = 1'b0;
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] bb, input int gap,
                       input logic [7:0] res, input string name);
        logic [3:0] nib [4];
        int start;
        nib[0] = a[7:4];
        nib[1] = a[3:0];
        nib[2] = bb[7:4];
        nib[3] = bb[3:0];
        do_reset();
        start = cycle;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    en = 1'b0;
                    data = 4'($urandom);
                    b7 = 1'($urandom);
                    cyc();
                end
            end
            en = 1'b1;
            data = nib[i];
            b7 = 1'($urandom);
            cyc();
        end
        expect_at(8'h00, start + 4 + 3 * gap, {name, "_pre"});
        expect_at(res, start + 5 + 3 * gap, {name, "_valid"});
        expect_at(res, start + 9 + 3 * gap, {name, "_hold"});
        for (int i = 0; i < 9; i++) begin
            en = 1'($urandom);
            data = 4'($urandom);
            b7 = 1'($urandom);
            cyc();
        end
    endtask

    initial begin
        do_reset();
        cyc();
        expect_at(8'h00, cycle, "idle_after_reset");
        cyc();

        run(8'h77, 8'h77, 0, 8'h78, "overflow");
        run(8'hD2, 8'h44, 0, 8'hDF, "neg10x3");
        run(8'hFA, 8'h78, 0, 8'hFF, "nan_x_inf");
        run(8'h78, 8'h00, 0, 8'h7F, "inf_x_zero");
        run(8'h38, 8'h38, 0, 8'h38, "one_x_one");
        run(8'h3F, 8'h3F, 0, 8'h46, "norm_trunc");
        run(8'h08, 8'h08, 0, 8'h00, "underflow");
        run(8'h80, 8'h40, 0, 8'h80, "negzero_x_two");
        run(8'hD2, 8'h44, 2, 8'hDF, "gapped");

        // Abort after two nibbles, then a clean load.
        do_reset();
        en = 1'b1; data = 4'h3; cyc();
        en = 1'b1; data = 4'h8; cyc();
        rst = 1'b1;
        cyc();
        expect_at(8'h00, cycle, "abort_in_reset");
        rst = 1'b0;
        en = 1'b1; data = 4'h3; cyc();
        expect_at(8'h00, cycle, "abort_reload");
        en = 1'b1; data = 4'h8; cyc();
        en = 1'b1; data = 4'h4; cyc();
        en = 1'b1; data = 4'h0; cyc();
        expect_at(8'h00, cycle, "abort_pre");
        expect_at(8'h40, cycle + 1, "abort_result");
        expect_at(8'h40, cycle + 6, "abort_hold");
        for (int i = 0; i < 8; i++) begin
            en = 1'($urandom);
            data = 4'($urandom);
            b7 = 1'($urandom);
            cyc();
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) cyc();
        while (sb.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s: never checked, due %0d", sb[0].name, sb[0].due);
            void'(sb.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
